bar_frame_loader: RTL and testbench
===================================

# bar_frame_loader

Sequencer between the Nios-written bar-height RAM (`vga_ram`) and the VGA controller. On each new-frame rising edge of `data_back`, it reads `NUM_BARS` heights over the RAM read port into a shadow register file. It then commits them atomically to the display height array only during vertical blanking, so a bar update never tears mid-frame. It replaces the ad-hoc counter/case readout and the `control_bit` handshake in the top level.

## Interface
Parameters:
- `NUM_BARS`, 20, number of bars/RAM words read per frame (≤ 2**`ADDR_W`)
- `HEIGHT_W`, 6, bits per bar height (RAM data width)
- `ADDR_W`, 6, RAM read-address width
- `BASE_ADDR`, 0, RAM address of bar 0
- `RD_LATENCY`, 2, cycles from address driven to `ram_q` valid (1..4)

Ports:
- `CLOCK_50` in 1: sole clock; all logic on rising edge
- `reset_n` in 1: synchronous, active-low reset
- `data_back` in 1: Nios PIO level; a 0→1 transition means the RAM holds a new frame
- `vblank` in 1: high during VGA vertical blanking, synchronous to `CLOCK_50`
- `ram_rdaddress` out `ADDR_W`: RAM read address, registered
- `ram_q` in `HEIGHT_W`: RAM read data
- `heights` out `NUM_BARS*HEIGHT_W`: display heights, bar k at bits [k*HEIGHT_W +: HEIGHT_W]
- `busy` out 1: high whenever the state is not IDLE
- `update_pulse` out 1: one-cycle pulse in the cycle after a commit
- `overrun` out 1: one-cycle pulse when a `data_back` edge is dropped
- `frame_valid` out 1: high from the first commit until reset

## Operation
- Edge detection: `edge = data_back & ~data_back_q`. `data_back_q` resets to 1, so a level already high at reset release is not an edge.
- State IDLE:
  - Edge → READ.
  - `ram_rdaddress` ← `BASE_ADDR`.
  - Issue counter ← 1; capture counter ← 0.
- State READ:
  - Issue counter advances `ram_rdaddress` by 1 per cycle until `BASE_ADDR+NUM_BARS-1` has been driven.
  - `shadow[k]` ← `ram_q` exactly `RD_LATENCY` cycles after address `BASE_ADDR+k` was driven.
  - After capturing `shadow[NUM_BARS-1]` → WAIT_VBLANK, and `ram_rdaddress` ← `BASE_ADDR`.
- State WAIT_VBLANK: in the first cycle `vblank`=1:
  - `heights` ← shadow (all bars in one edge).
  - `update_pulse` ← 1 and `frame_valid` ← 1.
  - Next state IDLE.
  - With `vblank` held low, it waits indefinitely and `heights` is unchanged.
- Edge accepted only in IDLE. An edge in READ or WAIT_VBLANK (including the commit cycle) is dropped, and `overrun` pulses in the following cycle.
- `heights` changes only on commit. The shadow register file is never visible at the outputs.
- Address arithmetic is unsigned and `ADDR_W` wide. `BASE_ADDR+NUM_BARS-1` must fit in `ADDR_W` bits; an elaboration-time assertion enforces this. No wrap-around occurs in range.

## Timing
- Reset values: state IDLE, `ram_rdaddress`=`BASE_ADDR`, `heights`=0, shadow=0, `busy`=0, `update_pulse`=0, `overrun`=0, `frame_valid`=0.
- Let cycle 0 be the cycle in which `edge`=1. Then:
  - `busy`=1 from cycle 1.
  - `ram_rdaddress`=`BASE_ADDR+k` in cycle k+1.
  - `shadow[k]` is sampled at the end of cycle k+1+`RD_LATENCY`.
  - WAIT_VBLANK is entered in cycle `NUM_BARS`+`RD_LATENCY`+1; with defaults this is cycle 23.
- Commit at the end of the first WAIT_VBLANK cycle with `vblank`=1. `update_pulse`=1, `busy`=0 and the new `heights` all appear in the next cycle.
  - Minimum edge-to-`update_pulse` latency with defaults: 24 cycles.
- Reset mid-operation: everything returns to reset values in the next cycle. A partial frame is discarded and produces no `update_pulse`.

## Structure
- Package `audiovis_pkg`:
  - Constants `NUM_BARS`, `HEIGHT_W`, `ADDR_W`.
  - `typedef logic [HEIGHT_W-1:0] height_t`.
  - State enum `loader_state_t` {IDLE, READ, WAIT_VBLANK}.
  - The VGA controller also uses this package.
- Sub-module `rise_detect`: one-flop rising-edge detector with reset value parameter `INIT`. Used here for `data_back`.

## Test plan
- RAM model (`RD_LATENCY`=2) holds word k = k+10; `vblank` held 1; edge at cycle 0:
  - `ram_rdaddress` reads 0..19 in cycles 1..20.
  - `update_pulse` occurs in cycle 24, and only once.
  - `heights[k]` = k+10; `frame_valid`=1.
- Same RAM contents, `vblank`=0 for 1000 cycles after the capture:
  - `busy` stays 1 and `heights` keeps its prior value.
  - Raising `vblank` makes `update_pulse` follow one cycle later.
- Second `data_back` edge at cycle 5 of a load:
  - `overrun`=1 in cycle 6.
  - Exactly one `update_pulse` follows; the data is from the first load.
- `reset_n`=0 in cycle 10 of READ:
  - From cycle 11 all outputs are at reset values.
  - No `update_pulse` occurs.
  - A new edge then loads normally.
- `data_back` high through reset release:
  - No load while it stays high.
  - A 1→0→1 toggle triggers a load.
- RAM rewritten to word k = 63−k between two loads: after the second commit `heights[0]`=63 and `heights[19]`=44; boundary values are preserved.

Source files
------------

// File: rtl/audiovis_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audiovis_pkg
//  Description : Shared constants and types for the audio-visualiser display
//                path (bar-frame loader and VGA controller).
//  Contents    : NUM_BARS, HEIGHT_W, ADDR_W constants, height_t bar height
//                type, loader_state_t sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package audiovis_pkg;

  localparam int NUM_BARS = 20;
  localparam int HEIGHT_W = 6;
  localparam int ADDR_W   = 6;

  typedef logic [HEIGHT_W-1:0] height_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    READ        = 2'd1,
    WAIT_VBLANK = 2'd2
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/bar_frame_loader_rise_detect.sv
`default_nettype none
// ============================================================================
//  Module      : rise_detect
//  Description : One-flop rising-edge detector with a configurable reset
//                value for the history flop.
//  Ports       : clk    - clock
//                rst_n  - synchronous active-low reset
//                i_d    - level input (synchronous to clk)
//                o_rise - high for the cycle in which i_d is 1 and was 0
//  Revision    : 1.0 - initial release
// ============================================================================
module rise_detect #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise
);
  import audiovis_pkg::*;

  logic d_q;
  logic d_d;

  assign d_d = i_d;

  // INIT=1 makes a level that is already high at reset release look "old",
  // so it does not register as an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q <= INIT;
    end else begin
      d_q <= d_d;
    end
  end

  assign o_rise = i_d & ~d_q;

endmodule
`default_nettype wire

// File: rtl/bar_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : bar_frame_loader
//  Description : On each rising edge of data_back, reads NUM_BARS bar heights
//                from the bar-height RAM into a shadow register file, then
//                commits them to the display height array in the first
//                vertical-blanking cycle so a frame never tears.
//  Ports       : CLOCK_50      - clock
//                reset_n       - synchronous active-low reset
//                data_back     - new-frame level from Nios PIO
//                vblank        - VGA vertical blanking
//                ram_rdaddress - registered RAM read address
//                ram_q         - RAM read data (RD_LATENCY cycles after addr)
//                heights       - committed heights, bar k at [k*HEIGHT_W +:]
//                busy          - sequencer not idle
//                update_pulse  - one-cycle pulse after a commit
//                overrun       - one-cycle pulse after a dropped edge
//                frame_valid   - set by the first commit
//  Revision    : 1.0 - initial release
// ============================================================================
module bar_frame_loader #(
  parameter int NUM_BARS   = audiovis_pkg::NUM_BARS,
  parameter int HEIGHT_W   = audiovis_pkg::HEIGHT_W,
  parameter int ADDR_W     = audiovis_pkg::ADDR_W,
  parameter int BASE_ADDR  = 0,
  parameter int RD_LATENCY = 2
) (
  input  logic                         CLOCK_50,
  input  logic                         reset_n,
  input  logic                         data_back,
  input  logic                         vblank,
  output logic [ADDR_W-1:0]            ram_rdaddress,
  input  logic [HEIGHT_W-1:0]          ram_q,
  output logic [NUM_BARS*HEIGHT_W-1:0] heights,
  output logic                         busy,
  output logic                         update_pulse,
  output logic                         overrun,
  output logic                         frame_valid
);
  import audiovis_pkg::*;

  localparam int CNT_W = $clog2(NUM_BARS + 1);
  localparam int LAT_W = $clog2(RD_LATENCY + 1);

  localparam logic [CNT_W-1:0]  c_num_bars   = CNT_W'(NUM_BARS);
  localparam logic [CNT_W-1:0]  c_last_bar   = CNT_W'(NUM_BARS - 1);
  localparam logic [LAT_W-1:0]  c_rd_latency = LAT_W'(RD_LATENCY);
  localparam logic [ADDR_W-1:0] c_base_addr  = ADDR_W'(BASE_ADDR);

  generate
    if (BASE_ADDR + NUM_BARS - 1 >= 2 ** ADDR_W) begin : g_addr_range_err
      $error("bar_frame_loader: BASE_ADDR+NUM_BARS-1 does not fit in ADDR_W bits");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_latency_err
      $error("bar_frame_loader: RD_LATENCY must be 1..4");
    end
  endgenerate

  loader_state_t                 state_q, state_d;
  logic [ADDR_W-1:0]             ram_rdaddress_q, ram_rdaddress_d;
  logic [CNT_W-1:0]              issue_q, issue_d;
  logic [CNT_W-1:0]              capture_q, capture_d;
  logic [LAT_W-1:0]              lat_q, lat_d;
  logic [NUM_BARS*HEIGHT_W-1:0]  shadow_q, shadow_d;
  logic [NUM_BARS*HEIGHT_W-1:0]  heights_q, heights_d;
  logic                          update_pulse_q, update_pulse_d;
  logic                          overrun_q, overrun_d;
  logic                          frame_valid_q, frame_valid_d;
  logic                          db_edge;

  rise_detect #(
    .INIT (1'b1)
  ) u_db_rise (
    .clk    (CLOCK_50),
    .rst_n  (reset_n),
    .i_d    (data_back),
    .o_rise (db_edge)
  );

  // State and datapath registers
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      ram_rdaddress_q <= c_base_addr;
      issue_q         <= CNT_W'(1);
      capture_q       <= '0;
      lat_q           <= '0;
      shadow_q        <= '0;
      heights_q       <= '0;
      update_pulse_q  <= 1'b0;
      overrun_q       <= 1'b0;
      frame_valid_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      ram_rdaddress_q <= ram_rdaddress_d;
      issue_q         <= issue_d;
      capture_q       <= capture_d;
      lat_q           <= lat_d;
      shadow_q        <= shadow_d;
      heights_q       <= heights_d;
      update_pulse_q  <= update_pulse_d;
      overrun_q       <= overrun_d;
      frame_valid_q   <= frame_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (db_edge) state_d = READ;
      READ:        if (lat_q == c_rd_latency && capture_q == c_last_bar) state_d = WAIT_VBLANK;
      WAIT_VBLANK: if (vblank) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    ram_rdaddress_d = ram_rdaddress_q;
    issue_d         = issue_q;
    capture_d       = capture_q;
    lat_d           = lat_q;
    shadow_d        = shadow_q;
    heights_d       = heights_q;
    update_pulse_d  = 1'b0;
    frame_valid_d   = frame_valid_q;
    // Any edge seen outside IDLE (commit cycle included) is lost.
    overrun_d       = db_edge && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        // Address BASE_ADDR is already on the bus, so the first READ cycle
        // issues bar 0 and the counter starts at the next address.
        ram_rdaddress_d = c_base_addr;
        issue_d         = CNT_W'(1);
        capture_d       = '0;
        lat_d           = '0;
      end
      READ: begin
        if (issue_q != c_num_bars) begin
          ram_rdaddress_d = c_base_addr + ADDR_W'(issue_q);
          issue_d         = issue_q + 1'b1;
        end
        // lat_q counts the READ cycles until the data of bar 0 arrives;
        // from then on one bar is captured per cycle, in issue order.
        if (lat_q != c_rd_latency) begin
          lat_d = lat_q + 1'b1;
        end else begin
          shadow_d[int'(capture_q)*HEIGHT_W +: HEIGHT_W] = ram_q;
          capture_d = capture_q + 1'b1;
          if (capture_q == c_last_bar) ram_rdaddress_d = c_base_addr;
        end
      end
      WAIT_VBLANK: begin
        if (vblank) begin
          heights_d      = shadow_q;
          update_pulse_d = 1'b1;
          frame_valid_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ram_rdaddress = ram_rdaddress_q;
  assign heights       = heights_q;
  assign busy          = (state_q != IDLE);
  assign update_pulse  = update_pulse_q;
  assign overrun       = overrun_q;
  assign frame_valid   = frame_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_bar_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bar_frame_loader
//  Description : Self-checking bench for bar_frame_loader with a two-cycle
//                latency RAM model, a cycle-level reference model and
//                directed scenarios with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bar_frame_loader;

  localparam int NB   = 20;
  localparam int HW   = 6;
  localparam int AW   = 6;
  localparam int BASE = 0;
  localparam int LAT  = 2;

  logic              CLOCK_50  = 1'b0;
  logic              reset_n   = 1'b0;
  logic              data_back = 1'b0;
  logic              vblank    = 1'b1;
  logic [AW-1:0]     ram_rdaddress;
  logic [HW-1:0]     ram_q;
  logic [NB*HW-1:0]  heights;
  logic              busy, update_pulse, overrun, frame_valid;

  always #5 CLOCK_50 = ~CLOCK_50;

  bar_frame_loader #(
    .NUM_BARS   (NB),
    .HEIGHT_W   (HW),
    .ADDR_W     (AW),
    .BASE_ADDR  (BASE),
    .RD_LATENCY (LAT)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .reset_n       (reset_n),
    .data_back     (data_back),
    .vblank        (vblank),
    .ram_rdaddress (ram_rdaddress),
    .ram_q         (ram_q),
    .heights       (heights),
    .busy          (busy),
    .update_pulse  (update_pulse),
    .overrun       (overrun),
    .frame_valid   (frame_valid)
  );

  // RAM model: data for the address present in cycle c shows up in c+LAT
  logic [HW-1:0] mem  [0:63];
  logic [HW-1:0] pipe [0:LAT-1];
  always @(posedge CLOCK_50) begin
    pipe[0] <= mem[ram_rdaddress];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_q = pipe[LAT-1];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_upd  = 0;

  always @(posedge CLOCK_50) cyc++;

  task automatic chk(input string name, input logic [NB*HW-1:0] act, input logic [NB*HW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model. m_t = cycles since the accepted edge (0 = idle).
  int               m_t       = 0;
  logic             m_prev_db = 1'b1;
  logic [NB*HW-1:0] m_shadow  = '0;
  logic [NB*HW-1:0] m_heights = '0;
  logic             m_upd     = 1'b0;
  logic             m_ovr     = 1'b0;
  logic             m_fv      = 1'b0;

  always @(negedge CLOCK_50) begin
    logic e;
    int   exp_addr;
    if (cyc >= 3) begin
      exp_addr = BASE;
      if (m_t >= 1 && m_t <= NB)            exp_addr = BASE + m_t - 1;
      else if (m_t > NB && m_t <= NB + LAT) exp_addr = BASE + NB - 1;
      chk("busy",          busy,          (m_t != 0));
      chk("ram_rdaddress", ram_rdaddress, exp_addr[AW-1:0]);
      chk("heights",       heights,       m_heights);
      chk("update_pulse",  update_pulse,  m_upd);
      chk("overrun",       overrun,       m_ovr);
      chk("frame_valid",   frame_valid,   m_fv);
    end
    if (update_pulse === 1'b1) n_upd++;
    // advance model to next cycle using this cycle's inputs
    if (!reset_n) begin
      m_t = 0; m_prev_db = 1'b1; m_heights = '0; m_shadow = '0;
      m_upd = 1'b0; m_ovr = 1'b0; m_fv = 1'b0;
    end else begin
      e         = data_back && !m_prev_db;
      m_prev_db = data_back;
      m_ovr     = e && (m_t != 0);
      m_upd     = 1'b0;
      if (m_t != 0 && m_t >= NB + LAT + 1 && vblank) begin
        m_heights = m_shadow; m_upd = 1'b1; m_fv = 1'b1; m_t = 0;
      end else if (m_t != 0) begin
        m_t++;
      end else if (e) begin
        m_t = 1;
        for (int k = 0; k < NB; k++) m_shadow[k*HW +: HW] = mem[BASE + k];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_upd(input int bound, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (update_pulse !== 1'b1 && n < bound);
    checks++;
    if (update_pulse !== 1'b1) begin
      errors++;
      $display("FAIL wait_update: got no update_pulse within %0d cycles, expected one", bound);
    end
  endtask

  initial begin
    int n;
    int base;
    logic [NB*HW-1:0] saved;
    for (int k = 0; k < 64; k++) mem[k] = HW'(k + 10);

    // ---- reset, then basic load with vblank held high
    reset_n = 1'b0; data_back = 1'b0; vblank = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    chk("rst_heights", heights, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_busy", busy, 0);
    base = n_upd;
    data_back = 1'b1;                       // cycle 0
    for (int k = 1; k <= NB; k++) begin
      tick(1);
      chk("addr_seq", ram_rdaddress, k - 1);
    end
    wait_upd(100, n);
    chk("update_latency", 20 + n, 24);
    tick(30);
    chk("single_update", n_upd - base, 1);
    chk("lit_h0", heights[0 +: HW], 10);
    chk("lit_h19", heights[19*HW +: HW], 29);
    chk("lit_fv", frame_valid, 1);

    // ---- vblank low for 1000 cycles: hold and wait
    data_back = 1'b0; tick(2);
    data_back = 1'b1; vblank = 1'b0;
    saved = heights;
    tick(1000);
    chk("wait_busy", busy, 1);
    chk("wait_heights", heights, saved);
    vblank = 1'b1;
    tick(1);
    chk("vblank_update", update_pulse, 1);

    // ---- overrun: second edge at cycle 5
    data_back = 1'b0; tick(2);
    data_back = 1'b1;                       // cycle 0
    tick(1); data_back = 1'b0;              // cycle 1
    tick(4); data_back = 1'b1;              // cycle 5
    tick(1);
    chk("overrun_c6", overrun, 1);
    base = n_upd;
    tick(60);
    chk("overrun_one_update", n_upd - base, 1);
    chk("overrun_h19", heights[19*HW +: HW], 29);

    // ---- reset in READ
    data_back = 1'b0; tick(2);
    data_back = 1'b1;                       // cycle 0
    tick(10);                               // cycle 10
    reset_n = 1'b0;
    tick(1);                                // cycle 11
    reset_n = 1'b1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_heights", heights, 0);
    chk("mid_rst_fv", frame_valid, 0);
    chk("mid_rst_addr", ram_rdaddress, BASE);
    base = n_upd;
    tick(40);
    chk("mid_rst_no_update", n_upd - base, 0);
    data_back = 1'b0; tick(1);
    data_back = 1'b1;
    wait_upd(100, n);
    chk("reload_latency", n, 24);

    // ---- data_back high through reset release
    reset_n = 1'b0; data_back = 1'b1;
    tick(2);
    reset_n = 1'b1;
    base = n_upd;
    tick(40);
    chk("high_rel_busy", busy, 0);
    chk("high_rel_no_update", n_upd - base, 0);
    data_back = 1'b0; tick(1);
    data_back = 1'b1;
    wait_upd(100, n);
    chk("toggle_fv", frame_valid, 1);

    // ---- RAM rewritten between loads
    for (int k = 0; k < 64; k++) mem[k] = HW'(63 - k);
    data_back = 1'b0; tick(1);
    data_back = 1'b1;
    wait_upd(100, n);
    chk("rewrite_h0", heights[0 +: HW], 63);
    chk("rewrite_h19", heights[19*HW +: HW], 44);
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
